mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-port arbiter/sequencer that shares the single-ported main memory between
//  instruction fetch (port 0) and data load/store (port 1) of the ARC datapath.
//  Accepts req/ack transactions, round-robins on contention, drives the memory
//  address/data_in/rd/wr pins, and returns read data registered with an ack pulse.
//  Memory has one-cycle registered read and write-on-posedge semantics.
// PARAMETERS
//  AW  32  address width, passed to memory unchanged (word index, no shifting)
//  DW  32  data width
// PORTS
//  clk         in   1   system clock, all logic on posedge
//  rst         in   1   synchronous, active-high reset
//  p0_req      in   1   fetch request; held high until p0_ack
//  p0_addr     in   AW  fetch address (read only)
//  p0_ack      out  1   one-cycle pulse: p0 transaction complete, p0_rdata valid
//  p0_rdata    out  DW  fetch read data, held until next p0 ack
//  p1_req      in   1   data request; held high until p1_ack
//  p1_we       in   1   1 = write, 0 = read
//  p1_addr     in   AW  data address
//  p1_wdata    in   DW  write data
//  p1_ack      out  1   one-cycle pulse: p1 transaction complete
//  p1_rdata    out  DW  load data, held until next p1 read ack
//  mem_addr    out  AW  to memory address
//  mem_wdata   out  DW  to memory data_in
//  mem_rd      out  1   to memory rd
//  mem_wr      out  1   to memory wr
//  mem_rdata   in   DW  from memory data_out
//  busy        out  1   high whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0 (acks, rdata, mem_* , busy), last_grant=1
//    so p0 wins first contention. rst mid-transaction aborts it: no ack issued,
//    mem_rd/mem_wr low from the cycle after rst; requester must re-request.
//  - FSM IDLE -> ISSUE -> CAPTURE -> IDLE; every transaction exactly 3 cycles.
//  - IDLE: if any req, pick grant (below), latch grant id, addr, we, wdata into
//    registers; go ISSUE. mem_rd=mem_wr=0 in IDLE.
//  - ISSUE: mem_addr/mem_wdata from latched regs; mem_rd=~we, mem_wr=we (never
//    both). Memory samples at end of ISSUE.
//  - CAPTURE: mem_rd=mem_wr=0; ack of granted port high this cycle only;
//    for reads, granted rdata register loads mem_rdata at end of CAPTURE and
//    ack is asserted in the following IDLE cycle? NO: rdata is forwarded
//    combinationally from mem_rdata while ack is high AND registered for hold.
//    Next state IDLE unconditionally.
//  - Latency: req sampled high at edge N -> ack high in cycle N+2 (2nd cycle after).
//  - Handshake: requester drops req at the edge ending its ack cycle; req still
//    high in following IDLE is a new request. addr/we/wdata need be stable only
//    at the accepting edge (latched).
//  - Arbitration: only one req -> that port. Both -> port != last_grant;
//    last_grant updates on each grant. Back-to-back contention alternates 0,1,0,1.
//  - Non-granted req waits with no ack; no starvation (max wait one transaction).
//  - Writes on p0 impossible (no we pin); p1 write: p1_rdata unchanged.
//  - mem_addr/mem_wdata hold last latched values outside ISSUE (no toggling).
// STRUCTURE
//  - Shared package arc_mem_pkg: state encoding localparams ST_IDLE=2'd0,
//    ST_ISSUE=2'd1, ST_CAPTURE=2'd2; PORT_FETCH=1'b0, PORT_DATA=1'b1.
//  - Sub-module rr_arb2: inputs req[1:0], last_grant; output grant, grant_valid
//    (pure combinational picker). Top holds FSM, latches, outputs.
// TESTING (bench instantiates main_memory + mem_port_arbiter)
//  - Reset then p0_req addr=2052 -> p0_ack 2 cycles later, p0_rdata=32'hC2002810;
//    busy high 2 cycles.
//  - p1 write addr=2080 data=32'hDEADBEEF, then p1 read 2080 -> p1_rdata=
//    32'hDEADBEEF; mem_wr high exactly one cycle, mem_rd never during write.
//  - p0 and p1 req same edge, held 4 transactions -> grants p0,p1,p0,p1;
//    each ack 3 cycles apart; no overlap of p0_ack/p1_ack.
//  - p1 read 2056 while p0 idle, p0 req raised during ISSUE -> p0 granted
//    in IDLE after p1_ack; p0_ack 3 cycles after p1_ack.
//  - rst asserted in ISSUE of p1 write -> no p1_ack, all outputs 0 next cycle,
//    state IDLE; re-request after reset completes normally.
//  - req held high one extra cycle past ack -> second identical transaction
//    issued (documents handshake rule).

Source files
------------

// File: rtl/arc_mem_pkg.sv
// Shared encodings for the ARC main-memory port arbiter: FSM states and port ids.
package arc_mem_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ISSUE   = ST_ISSUE,
    S_CAPTURE = ST_CAPTURE
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; on contention the port that did not win last time wins.
module rr_arb2
  import arc_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    grant       = PORT_FETCH;
    if (&req) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported main memory between instruction fetch (port 0) and
// data load/store (port 1); every transaction takes exactly three cycles.
//
// state    | meaning
// IDLE     | no access in flight; picks a requester and latches its command
// ISSUE    | drives mem_rd or mem_wr for the latched command
// CAPTURE  | one-cycle ack to the granted port; read data forwarded and held
module mem_port_arbiter
  import arc_mem_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t    state_q, state_d;
  logic          grant_q, we_q, last_grant_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, p0_rdata_q, p1_rdata_q;
  logic          arb_grant, arb_valid;
  logic          accept;

  rr_arb2 u_rr_arb2 (
    .req         ({p1_req, p0_req}),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  assign accept = (state_q == S_IDLE) && arb_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= PORT_FETCH;
      we_q         <= 1'b0;
      last_grant_q <= PORT_DATA;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q      <= arb_grant;
        last_grant_q <= arb_grant;
        addr_q       <= arb_grant ? p1_addr : p0_addr;
        we_q         <= arb_grant & p1_we;
        // Fetch has no write data; keep the bus quiet instead of loading junk.
        if (arb_grant == PORT_DATA) begin
          wdata_q <= p1_wdata;
        end
      end
      if (p0_ack) begin
        p0_rdata_q <= mem_rdata;
      end
      if (p1_ack && !we_q) begin
        p1_rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    p0_ack  = 1'b0;
    p1_ack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mem_rd  = ~we_q;
        mem_wr  = we_q;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        p0_ack  = (grant_q == PORT_FETCH);
        p1_ack  = (grant_q == PORT_DATA);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  // Read data is visible in the ack cycle itself, then held from the register.
  assign p0_rdata  = p0_ack ? mem_rdata : p0_rdata_q;
  assign p1_rdata  = (p1_ack && !we_q) ? mem_rdata : p1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a one-cycle registered-read memory
// and a transaction-timeline reference model checked every cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0;
  logic [31:0] p0_addr = '0;
  logic        p1_req = 1'b0;
  logic        p1_we = 1'b0;
  logic [31:0] p1_addr = '0;
  logic [31:0] p1_wdata = '0;
  logic        p0_ack, p1_ack, mem_rd, mem_wr, busy;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_addr   (p0_addr),
    .p0_ack    (p0_ack),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_ack    (p1_ack),
    .p1_rdata  (p1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Main memory: write on posedge, one-cycle registered read.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[11:0]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[11:0]];
  end

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: each accepted request books its memory strobe in the next
  // cycle and its ack in the one after; the arbiter is free again one cycle later.
  localparam int NCYC = 4096;
  int          cyc = 0;
  int          idle_from = 0;
  bit          last_g = 1'b1;
  logic [31:0] hold0 = '0, hold1 = '0, m_addr = '0;
  bit          exp_ack0 [NCYC];
  bit          exp_ack1 [NCYC];
  bit          exp_p1rd [NCYC];
  bit          exp_rd   [NCYC];
  bit          exp_wr   [NCYC];
  bit          exp_busy [NCYC];
  logic [31:0] exp_d0   [NCYC];
  logic [31:0] exp_d1   [NCYC];
  logic [31:0] exp_wd   [NCYC];
  logic [31:0] shadow [logic [31:0]];
  bit          m_port, m_we;
  logic [31:0] m_a, m_d;

  int cnt_busy = 0, cnt_rd = 0, cnt_wr = 0, cnt_both = 0;
  int ack_port_q[$];
  int ack_cyc_q[$];

  always @(posedge clk) begin
    if (busy) cnt_busy++;
    if (mem_rd) cnt_rd++;
    if (mem_wr) cnt_wr++;
    if (p0_ack && p1_ack) cnt_both++;
    if (p0_ack) begin ack_port_q.push_back(0); ack_cyc_q.push_back(cyc); end
    if (p1_ack) begin ack_port_q.push_back(1); ack_cyc_q.push_back(cyc); end

    cyc++;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        exp_ack0[cyc+k] = 0; exp_ack1[cyc+k] = 0; exp_p1rd[cyc+k] = 0;
        exp_rd[cyc+k] = 0; exp_wr[cyc+k] = 0; exp_busy[cyc+k] = 0;
      end
      idle_from = cyc;
      last_g    = 1'b1;
      hold0     = '0;
      hold1     = '0;
      m_addr    = '0;
    end else begin
      if (exp_ack0[cyc-1]) hold0 = exp_d0[cyc-1];
      if (exp_ack1[cyc-1] && exp_p1rd[cyc-1]) hold1 = exp_d1[cyc-1];
      if ((cyc - 1 >= idle_from) && (p0_req || p1_req)) begin
        m_port = (p0_req && p1_req) ? !last_g : p1_req;
        last_g = m_port;
        m_a    = m_port ? p1_addr : p0_addr;
        m_we   = m_port && p1_we;
        m_d    = shadow.exists(m_a) ? shadow[m_a] : 32'h0;
        exp_busy[cyc] = 1; exp_busy[cyc+1] = 1;
        exp_rd[cyc]   = !m_we;
        exp_wr[cyc]   = m_we;
        exp_wd[cyc]   = p1_wdata;
        if (m_we) shadow[m_a] = p1_wdata;
        if (!m_port) begin
          exp_ack0[cyc+1] = 1; exp_d0[cyc+1] = m_d;
        end else begin
          exp_ack1[cyc+1] = 1; exp_p1rd[cyc+1] = !m_we; exp_d1[cyc+1] = m_d;
        end
        m_addr    = m_a;
        idle_from = cyc + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check1("p0_ack", p0_ack, exp_ack0[cyc]);
      check1("p1_ack", p1_ack, exp_ack1[cyc]);
      check1("busy", busy, exp_busy[cyc]);
      check1("mem_rd", mem_rd, exp_rd[cyc]);
      check1("mem_wr", mem_wr, exp_wr[cyc]);
      check32("mem_addr", mem_addr, m_addr);
      if (exp_wr[cyc]) check32("mem_wdata", mem_wdata, exp_wd[cyc]);
      check32("p0_rdata", p0_rdata, exp_ack0[cyc] ? exp_d0[cyc] : hold0);
      check32("p1_rdata", p1_rdata,
              (exp_ack1[cyc] && exp_p1rd[cyc]) ? exp_d1[cyc] : hold1);
    end
  end

  task automatic wait_ack(input bit port, output int c);
    c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? p1_ack : p0_ack) begin
        c = cyc;
        break;
      end
    end
    check1("ack_within_budget", c >= 0, 1'b1);
  endtask

  task automatic wait_busy();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1;
        break;
      end
    end
    check1("busy_within_budget", seen, 1'b1);
  endtask

  initial begin
    int c0, c1, c2, raise_c, nacks;
    int exp_seq [4];
    exp_seq = '{0, 1, 0, 1};

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[2052] = 32'hC2002810;
    mem[2056] = 32'h12345678;
    shadow[32'd2052] = 32'hC2002810;
    shadow[32'd2056] = 32'h12345678;

    // Reset
    repeat (2) @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check32("rst_p0_rdata", p0_rdata, 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;

    // Single fetch
    @(negedge clk);
    cnt_busy = 0;
    raise_c  = cyc;
    p0_addr  = 32'd2052;
    p0_req   = 1'b1;
    wait_ack(0, c0);
    check32("s1_p0_rdata", p0_rdata, 32'hC2002810);
    p0_req = 1'b0;
    check_int("s1_latency", c0 - raise_c, 2);
    repeat (2) @(negedge clk);
    check_int("s1_busy_cycles", cnt_busy, 2);
    check32("s1_p0_rdata_held", p0_rdata, 32'hC2002810);

    // Data write then read back
    @(negedge clk);
    cnt_wr = 0; cnt_rd = 0;
    p1_we = 1'b1; p1_addr = 32'd2080; p1_wdata = 32'hDEADBEEF; p1_req = 1'b1;
    wait_ack(1, c1);
    p1_req = 1'b0; p1_we = 1'b0;
    repeat (2) @(negedge clk);
    check_int("s2_wr_cycles", cnt_wr, 1);
    check_int("s2_rd_cycles", cnt_rd, 0);
    check32("s2_p1_rdata_after_write", p1_rdata, 32'h0);
    @(negedge clk);
    p1_addr = 32'd2080; p1_req = 1'b1;
    wait_ack(1, c1);
    check32("s2_p1_rdata", p1_rdata, 32'hDEADBEEF);
    p1_req = 1'b0;
    @(negedge clk);
    check32("s2_p1_rdata_held", p1_rdata, 32'hDEADBEEF);

    // Contention: both requests held for four transactions
    @(negedge clk);
    ack_port_q.delete(); ack_cyc_q.delete();
    cnt_both = 0;
    p0_addr = 32'd2052; p1_addr = 32'd2056; p1_we = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    nacks = 0;
    for (int i = 0; i < 40 && nacks < 4; i++) begin
      @(negedge clk);
      nacks += int'(p0_ack) + int'(p1_ack);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    check_int("s3_ack_count_budget", nacks, 4);
    @(negedge clk);
    check_int("s3_ack_queue", ack_port_q.size(), 4);
    if (ack_port_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check_int("s3_grant_order", ack_port_q[i], exp_seq[i]);
      for (int i = 1; i < 4; i++) check_int("s3_ack_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], 3);
    end
    check_int("s3_ack_overlap", cnt_both, 0);

    // Fetch arrives while a data read is in ISSUE
    @(negedge clk);
    p1_addr = 32'd2056; p1_we = 1'b0; p1_req = 1'b1;
    wait_busy();
    p0_addr = 32'd2052; p0_req = 1'b1;
    wait_ack(1, c1);
    p1_req = 1'b0;
    check32("s4_p1_rdata", p1_rdata, 32'h12345678);
    wait_ack(0, c0);
    p0_req = 1'b0;
    check_int("s4_p0_after_p1", c0 - c1, 3);
    check32("s4_p0_rdata", p0_rdata, 32'hC2002810);

    // Reset during ISSUE of a data write
    repeat (2) @(negedge clk);
    ack_port_q.delete(); ack_cyc_q.delete();
    p1_we = 1'b1; p1_addr = 32'd2084; p1_wdata = 32'hCAFEF00D; p1_req = 1'b1;
    wait_busy();
    rst = 1'b1; p1_req = 1'b0; p1_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check1("s5_busy", busy, 1'b0);
    check1("s5_p0_ack", p0_ack, 1'b0);
    check1("s5_p1_ack", p1_ack, 1'b0);
    check1("s5_mem_rd", mem_rd, 1'b0);
    check1("s5_mem_wr", mem_wr, 1'b0);
    check32("s5_mem_addr", mem_addr, 32'h0);
    check32("s5_mem_wdata", mem_wdata, 32'h0);
    check32("s5_p0_rdata", p0_rdata, 32'h0);
    check32("s5_p1_rdata", p1_rdata, 32'h0);
    repeat (4) @(negedge clk);
    check_int("s5_no_ack_after_abort", ack_port_q.size(), 0);
    p1_we = 1'b1; p1_addr = 32'd2084; p1_wdata = 32'hCAFEF00D; p1_req = 1'b1;
    wait_ack(1, c1);
    p1_req = 1'b0; p1_we = 1'b0;
    @(negedge clk);
    p1_addr = 32'd2084; p1_req = 1'b1;
    wait_ack(1, c1);
    p1_req = 1'b0;
    check32("s5_readback", p1_rdata, 32'hCAFEF00D);

    // Request held one cycle past ack issues a second transaction
    @(negedge clk);
    ack_port_q.delete(); ack_cyc_q.delete();
    p0_addr = 32'd2056; p0_req = 1'b1;
    wait_ack(0, c1);
    @(negedge clk);
    @(negedge clk);
    p0_req = 1'b0;
    wait_ack(0, c2);
    check_int("s6_second_txn_gap", c2 - c1, 3);
    check32("s6_p0_rdata", p0_rdata, 32'h12345678);
    repeat (3) @(negedge clk);
    check_int("s6_ack_count", ack_port_q.size(), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
